// File: rtl/lcd_char_buffer.sv
// Character frame buffer for the HD44780 LCD path: cursor/explicit writes, registered read
// port, dirty/ack handshake. Optional clear sweep is built when CHAR_BUF_CLEAR_EN is defined.
module lcd_char_buffer #(
    parameter int          ROWS      = 2,
    parameter int          COLS      = 16,
    parameter int          AW        = 5,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          wr_use_cursor,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          cur_set,
    input  logic [AW-1:0] cur_addr,
    input  logic          clr,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] cursor,
    output logic          busy,
    output logic          dirty,
    input  logic          refresh_ack
);

    localparam int            DEPTH   = ROWS * COLS;
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    rd_data_q;
    logic [AW-1:0] cursor_q, cursor_d;
    logic          dirty_q, dirty_d;

    logic          busy_w;
    logic          clear_wr;
    logic          clear_done;
    logic [AW-1:0] clr_idx_q;

`ifdef CHAR_BUF_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    state_t state_q;
    logic   busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_idx_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_idx_q == LAST_L) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_w     = busy_q;
    assign clear_wr   = (state_q == ST_CLEAR);
    assign clear_done = clear_wr && (clr_idx_q == LAST_L);
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign busy_w     = 1'b0;
    assign clear_wr   = 1'b0;
    assign clear_done = 1'b0;
    assign clr_idx_q  = '0;
`endif

    logic [AW-1:0] wr_tgt;
    logic          wr_ok;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    assign wr_tgt    = wr_use_cursor ? cursor_q : wr_addr;
    assign wr_ok     = wr_en && !busy_w && in_range(wr_tgt);
    assign mem_we    = clear_wr || wr_ok;
    assign mem_waddr = clear_wr ? clr_idx_q : wr_tgt;
    assign mem_wdata = clear_wr ? FILL_CHAR : wr_data;

    // Storage has no reset; contents survive rst_n and a clear interrupted by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr[IW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else if (in_range(rd_addr)) begin
            rd_data_q <= mem_q[rd_addr[IW-1:0]];
        end else begin
            rd_data_q <= FILL_CHAR;
        end
    end

    // cur_set outranks the post-write advance; the write itself still used the old cursor.
    always_comb begin
        cursor_d = cursor_q;
        if (clear_done) begin
            cursor_d = '0;
        end else if (!busy_w) begin
            if (cur_set) begin
                cursor_d = in_range(cur_addr) ? cur_addr : '0;
            end else if (wr_ok && wr_use_cursor) begin
                cursor_d = (cursor_q == LAST_L) ? '0 : cursor_q + 1'b1;
            end
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (refresh_ack) dirty_d = 1'b0;
        if (wr_ok || clear_done) dirty_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
            dirty_q  <= dirty_d;
        end
    end

    assign rd_data = rd_data_q;
    assign cursor  = cursor_q;
    assign busy    = busy_w;
    assign dirty   = dirty_q;

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Directed bench for lcd_char_buffer; AW is widened to 6 so out-of-range addresses are reachable.
// Define CHAR_BUF_CLEAR_EN for both DUT and bench to exercise the clear sweep.
module tb_lcd_char_buffer;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          wr_use_cursor;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          cur_set;
    logic [AW-1:0] cur_addr;
    logic          clr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          dirty;
    logic          refresh_ack;

    int n_vec = 0;
    int n_err = 0;

    lcd_char_buffer #(.ROWS(2), .COLS(16), .AW(AW), .FILL_CHAR(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_use_cursor(wr_use_cursor),
        .wr_addr(wr_addr), .wr_data(wr_data), .cur_set(cur_set), .cur_addr(cur_addr),
        .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data), .cursor(cursor),
        .busy(busy), .dirty(dirty), .refresh_ack(refresh_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_use_cursor = 1'b0; wr_addr = '0; wr_data = 8'h00;
        cur_set = 1'b0; cur_addr = '0; clr = 1'b0; refresh_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr = '0;
        rst_n = 1'b0;
        tick(); tick();
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        n_vec++; if (cursor !== 6'd0) begin n_err++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL reset_dirty got=%b exp=0", dirty); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cursor_fill();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_use_cursor = 1'b1; wr_data = 8'h41 + 8'(i);
            tick();
        end
        idle_inputs();
        n_vec++; if (cursor !== 6'd0) begin n_err++; $display("FAIL fill_cursor_wrap got=%0d exp=0", cursor); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL fill_dirty got=%b exp=1", dirty); end
        for (int i = 0; i < 32; i++) begin
            rd_addr = 6'(i);
            tick();
            n_vec++;
            if (rd_data !== 8'h41 + 8'(i)) begin
                n_err++; $display("FAIL fill_readback addr=%0d got=%h exp=%h", i, rd_data, 8'h41 + 8'(i));
            end
        end
    endtask

    task automatic test_explicit_rw();
        rd_addr = 6'd16;
        wr_en = 1'b1; wr_addr = 6'd17; wr_data = 8'h41;
        tick();
        idle_inputs();
        n_vec++; if (rd_data !== 8'h51) begin n_err++; $display("FAIL explicit_prev_read got=%h exp=51", rd_data); end
        rd_addr = 6'd17;
        tick();
        n_vec++; if (rd_data !== 8'h41) begin n_err++; $display("FAIL explicit_read17 got=%h exp=41", rd_data); end
        rd_addr = 6'd40;
        tick();
        n_vec++; if (rd_data !== 8'h20) begin n_err++; $display("FAIL oob_read40 got=%h exp=20", rd_data); end
    endtask

    task automatic test_read_during_write();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h11;
        tick();
        wr_data = 8'h55; rd_addr = 6'd3;
        tick();
        idle_inputs();
        n_vec++; if (rd_data !== 8'h11) begin n_err++; $display("FAIL rdw_old_data got=%h exp=11", rd_data); end
        tick();
        n_vec++; if (rd_data !== 8'h55) begin n_err++; $display("FAIL rdw_new_data got=%h exp=55", rd_data); end
    endtask

    task automatic test_cursor_priority();
        cur_set = 1'b1; cur_addr = 6'd31;
        tick();
        n_vec++; if (cursor !== 6'd31) begin n_err++; $display("FAIL cur_set31 got=%0d exp=31", cursor); end
        wr_en = 1'b1; wr_use_cursor = 1'b1; wr_data = 8'h7A; cur_set = 1'b1; cur_addr = 6'd5;
        tick();
        idle_inputs();
        n_vec++; if (cursor !== 6'd5) begin n_err++; $display("FAIL cur_set_priority got=%0d exp=5", cursor); end
        rd_addr = 6'd31;
        tick();
        n_vec++; if (rd_data !== 8'h7A) begin n_err++; $display("FAIL cur_write_old_cursor got=%h exp=7a", rd_data); end
        cur_set = 1'b1; cur_addr = 6'd33;
        tick();
        idle_inputs();
        n_vec++; if (cursor !== 6'd0) begin n_err++; $display("FAIL cur_set_oob got=%0d exp=0", cursor); end
    endtask

    task automatic test_dirty();
        refresh_ack = 1'b1;
        tick();
        idle_inputs();
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL dirty_ack_clears got=%b exp=0", dirty); end
        wr_en = 1'b1; wr_addr = 6'd40; wr_data = 8'hEE;
        tick();
        idle_inputs();
        n_vec++; if (dirty !== 1'b0) begin n_err++; $display("FAIL oob_write_dirty got=%b exp=0", dirty); end
        rd_addr = 6'd8;
        tick();
        n_vec++; if (rd_data !== 8'h49) begin n_err++; $display("FAIL oob_write_alias got=%h exp=49", rd_data); end
        wr_en = 1'b1; wr_addr = 6'd20; wr_data = 8'h33; refresh_ack = 1'b1;
        tick();
        idle_inputs();
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL dirty_set_wins got=%b exp=1", dirty); end
    endtask

`ifdef CHAR_BUF_CLEAR_EN
    task automatic test_clear();
        int busy_cycles;
        cur_set = 1'b1; cur_addr = 6'd7; refresh_ack = 1'b1;
        tick();
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles == 5) begin
                wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h99;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        idle_inputs();
        n_vec++; if (busy_cycles != 32) begin n_err++; $display("FAIL clear_busy_len got=%0d exp=32", busy_cycles); end
        n_vec++; if (cursor !== 6'd0) begin n_err++; $display("FAIL clear_cursor got=%0d exp=0", cursor); end
        n_vec++; if (dirty !== 1'b1) begin n_err++; $display("FAIL clear_dirty got=%b exp=1", dirty); end
        for (int i = 0; i < 32; i++) begin
            rd_addr = 6'(i);
            tick();
            n_vec++;
            if (rd_data !== 8'h20) begin n_err++; $display("FAIL clear_readback addr=%0d got=%h exp=20", i, rd_data); end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear2_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask
`else
    task automatic test_clear();
        cur_set = 1'b1; cur_addr = 6'd7;
        tick();
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_ignored_busy got=%b exp=0", busy); end
        n_vec++; if (cursor !== 6'd7) begin n_err++; $display("FAIL clr_ignored_cursor got=%0d exp=7", cursor); end
        rd_addr = 6'd0;
        tick();
        n_vec++; if (rd_data !== 8'h41) begin n_err++; $display("FAIL clr_ignored_mem got=%h exp=41", rd_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_cursor_fill();
        test_explicit_rw();
        test_read_during_write();
        test_cursor_priority();
        test_dirty();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
